// File: rtl/adder_pipe_acc.sv
// Segmented carry-pipelined two's-complement adder/subtractor with valid/ready handshake.
// Optional output saturation on signed overflow is enabled by defining ADDER_PIPE_SAT_EN.
module adder_pipe_acc #(
    parameter int sigWidth   = 4,
    parameter int low_expand = 2,
    parameter int SEGMENTS   = 2,
    localparam int W         = sigWidth + low_expand + 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int SEG = W / SEGMENTS;

    // Per-stage registers: full-width copies of a and b' travel with their
    // partially formed sum so each stage only ever adds its own segment.
    logic         v_r  [SEGMENTS];
    logic [W-1:0] a_r  [SEGMENTS];
    logic [W-1:0] bp_r [SEGMENTS];
    logic [W-1:0] s_r  [SEGMENTS];
    logic         c_r  [SEGMENTS];

    // Tap k is the input of stage k; tap SEGMENTS is the output of the last stage.
    logic         tap_v  [SEGMENTS+1];
    logic [W-1:0] tap_a  [SEGMENTS+1];
    logic [W-1:0] tap_bp [SEGMENTS+1];
    logic [W-1:0] tap_s  [SEGMENTS+1];
    logic         tap_c  [SEGMENTS+1];

    logic [SEG:0] seg_sum [SEGMENTS];
    logic [W-1:0] s_nxt   [SEGMENTS];

    logic         stall;
    logic [W-1:0] raw_sum;

    assign stall    = v_r[SEGMENTS-1] && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        tap_v[0]  = in_valid;
        tap_a[0]  = a;
        tap_bp[0] = sub ? ~b : b;
        tap_s[0]  = '0;
        tap_c[0]  = sub;
        for (int k = 0; k < SEGMENTS; k++) begin
            tap_v[k+1]  = v_r[k];
            tap_a[k+1]  = a_r[k];
            tap_bp[k+1] = bp_r[k];
            tap_s[k+1]  = s_r[k];
            tap_c[k+1]  = c_r[k];
        end
    end

    // Each stage adds one segment using the carry registered by the stage before.
    always_comb begin
        for (int k = 0; k < SEGMENTS; k++) begin
            seg_sum[k] = {1'b0, tap_a[k][k*SEG +: SEG]}
                       + {1'b0, tap_bp[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, tap_c[k]};
            s_nxt[k]   = tap_s[k];
            s_nxt[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
    end

    // NOTE: the datapath registers are reset as well as the valid bits, so the
    // outputs read as zero during reset and ovf cannot glitch from stale operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SEGMENTS; k++) begin
                v_r[k]  <= 1'b0;
                a_r[k]  <= '0;
                bp_r[k] <= '0;
                s_r[k]  <= '0;
                c_r[k]  <= 1'b0;
            end
        end else if (!stall) begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // stage's old value on the same edge, which is what makes this a pipeline.
            for (int k = 0; k < SEGMENTS; k++) begin
                v_r[k]  <= tap_v[k];
                a_r[k]  <= tap_a[k];
                bp_r[k] <= tap_bp[k];
                s_r[k]  <= s_nxt[k];
                c_r[k]  <= seg_sum[k][SEG];
            end
        end
    end

    assign out_valid = tap_v[SEGMENTS];
    assign raw_sum   = tap_s[SEGMENTS];
    assign cout      = tap_c[SEGMENTS];
    assign ovf       = (tap_a[SEGMENTS][W-1] == tap_bp[SEGMENTS][W-1])
                    && (raw_sum[W-1] != tap_a[SEGMENTS][W-1]);

`ifdef ADDER_PIPE_SAT_EN
    // Clamp toward the sign of a: positive overflow saturates to max, negative to min.
    assign sum = !ovf                  ? raw_sum :
                 tap_a[SEGMENTS][W-1]  ? {1'b1, {(W-1){1'b0}}} :
                                         {1'b0, {(W-1){1'b1}}};
`else
    assign sum = raw_sum;
`endif

endmodule

// File: tb/tb_adder_pipe_acc.sv
// Directed bench for adder_pipe_acc at default parameters (W=10, SEGMENTS=2).
// Covers single transactions, a stalled stream and a mid-flight reset.
module tb_adder_pipe_acc;

    localparam int W = 10;

`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_pipe_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] raw_sum;
        logic [W-1:0] sat_sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_sum(input vec_t v);
        return (SAT_BUILD && v.ovf) ? v.sat_sum : v.raw_sum;
    endfunction

    // One transaction in isolation: latency, sum, cout and ovf.
    task automatic send_one(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        sub = v.sub; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " sum"},  32'(sum),  32'(exp_sum(v)));
        check({tag, " cout"}, 32'(cout), 32'(v.cout));
        check({tag, " ovf"},  32'(ovf),  32'(v.ovf));
    endtask

    vec_t vecs [10];
    vec_t strm [6];

    logic [W-1:0] exp_q [$];
    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf, held_valid, stalled;
    int           sent, got, stall_cycles, stale;

    initial begin
        //          sub   a        b        raw      sat      cout  ovf
        vecs[0] = '{1'b0, 10'h01F, 10'h001, 10'h020, 10'h020, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 10'h1FF, 10'h001, 10'h200, 10'h1FF, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 10'h000, 10'h001, 10'h3FF, 10'h3FF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 10'h005, 10'h003, 10'h002, 10'h002, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 10'h3FF, 10'h001, 10'h000, 10'h000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 10'h200, 10'h001, 10'h1FF, 10'h200, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 10'h155, 10'h0AA, 10'h1FF, 10'h1FF, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 10'h100, 10'h100, 10'h200, 10'h1FF, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 10'h2AA, 10'h155, 10'h155, 10'h200, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 10'h0E0, 10'h020, 10'h100, 10'h100, 1'b0, 1'b0};

        strm[0] = '{1'b0, 10'h010, 10'h005, 10'h015, 10'h015, 1'b0, 1'b0};
        strm[1] = '{1'b1, 10'h020, 10'h001, 10'h01F, 10'h01F, 1'b1, 1'b0};
        strm[2] = '{1'b0, 10'h0FF, 10'h001, 10'h100, 10'h100, 1'b0, 1'b0};
        strm[3] = '{1'b0, 10'h123, 10'h011, 10'h134, 10'h134, 1'b0, 1'b0};
        strm[4] = '{1'b1, 10'h300, 10'h100, 10'h200, 10'h200, 1'b1, 1'b0};
        strm[5] = '{1'b0, 10'h07F, 10'h081, 10'h100, 10'h100, 1'b0, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset sum",       32'(sum),       32'd0);
        check("reset cout",      32'(cout),      32'd0);
        check("reset ovf",       32'(ovf),       32'd0);
        rst_n = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream with out_ready low during cycles 3..5
        sent = 0; got = 0; stall_cycles = 0; held_valid = 1'b0;
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                sub = strm[sent].sub; a = strm[sent].a; b = strm[sent].b;
            end
            #1;
            stalled = out_valid && !out_ready;
            check("stream in_ready", 32'(in_ready), 32'(!stalled));
            if (stalled) begin
                stall_cycles++;
                if (held_valid) begin
                    check("stream hold sum",  32'(sum),  32'(held_sum));
                    check("stream hold cout", 32'(cout), 32'(held_cout));
                    check("stream hold ovf",  32'(ovf),  32'(held_ovf));
                end else begin
                    held_sum = sum; held_cout = cout; held_ovf = ovf; held_valid = 1'b1;
                end
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("stream extra result", 32'd1, 32'd0);
                else check($sformatf("stream result%0d", got), 32'(sum), 32'(exp_q.pop_front()));
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(exp_sum(strm[sent]));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream results received", 32'(got), 32'd6);
        check("stream stall cycles", 32'(stall_cycles), 32'd3);
        repeat (3) @(negedge clk);
        check("stream no duplicate", 32'(out_valid), 32'd0);

        // Reset while two results are in flight
        @(negedge clk);
        sub = 1'b0; a = 10'h155; b = 10'h0AA; in_valid = 1'b1;
        @(negedge clk);
        a = 10'h011; b = 10'h022;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset sum",       32'(sum),       32'd0);
        check("midreset in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midreset stale results", 32'(stale), 32'd0);
        send_one('{1'b0, 10'h0AB, 10'h011, 10'h0BC, 10'h0BC, 1'b0, 1'b0}, "postreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
